pulse_hs_rx: RTL

//   Receiving end of a toggle req/ack handshake that carries a DW-bit word from the clk_fast domain into clk_slow.

---
 rtl/pulse_hs_rx_pkg.sv | 21 ++
 rtl/pulse_hs_rx_bit_sync.sv | 29 ++
 rtl/pulse_hs_rx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pulse_hs_rx_pkg.sv
// pulse_hs_rx_pkg
//   Definitions shared by both ends of the toggle req/ack handshake.
//   - FSM state codes: IDLE, WAIT_SPACE
//   - Synchroniser depth minimum and the check helper for it
//   - Receive buffer depth
package pulse_hs_rx_pkg;

    // Legacy-compatible state codes; the transmit end decodes the same values.
    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] WAIT_SPACE = 1'b1;

    // Fewer than two flops gives no metastability settling time.
    localparam int unsigned SYNC_MIN  = 2;

    localparam int unsigned BUF_DEPTH = 2;

    function automatic logic sync_stages_ok(input int unsigned n);
        return n >= SYNC_MIN;
    endfunction

endpackage

// File: rtl/pulse_hs_rx_bit_sync.sv
// bit_sync
//   Multi-flop single-bit synchroniser with asynchronous active-low reset to 0.
//   Ports:
//     clk_i    in   destination-domain clock
//     rst_n_i  in   asynchronous active-low reset
//     d_i      in   asynchronous input bit
//     q_o      out  synchronised bit (last stage)
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_hs_rx.sv
// pulse_hs_rx
//   Receive end of a toggle req/ack handshake carrying a DW-bit word into clk_slow.
//   Each req_tgl level change is one word; the word is captured into a 2-entry
//   FWFT buffer and ack_tgl flips. When the buffer is full the ack is withheld
//   (WAIT_SPACE) so the source keeps req_data stable; a further req_tgl change
//   during that wait sets the sticky err_proto.
//   Ports:
//     clk_slow    in   receive clock
//     rst_n       in   asynchronous active-low reset
//     req_tgl     in   request toggle (async)
//     req_data    in   request word (async, stable until ack)
//     ack_tgl     out  acknowledge toggle
//     dout_valid  out  buffer head valid
//     dout_data   out  buffer head word
//     dout_ready  in   consumer accept
//     evt_cnt     out  captured word count (wraps)
//     busy        out  waiting for buffer space
//     err_proto   out  sticky protocol error
module pulse_hs_rx
    import pulse_hs_rx_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_slow,
    input  logic             rst_n,
    input  logic             req_tgl,
    input  logic [DW-1:0]    req_data,
    output logic             ack_tgl,
    output logic             dout_valid,
    output logic [DW-1:0]    dout_data,
    input  logic             dout_ready,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             busy,
    output logic             err_proto
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_sync_stages_check
        $error("pulse_hs_rx: SYNC_STAGES must be at least %0d", SYNC_MIN);
    end

    logic             req_s;
    logic             req_d_q;
    logic             evt;
    logic [0:0]       state_q, state_d;
    logic [DW-1:0]    head_q, head_d;
    logic [DW-1:0]    tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;
    logic             space;
    logic             capture;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i   (clk_slow),
        .rst_n_i (rst_n),
        .d_i     (req_tgl),
        .q_o     (req_s)
    );

    assign evt   = req_s ^ req_d_q;
    assign pop   = (count_q != 2'd0) & dout_ready;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign space = (count_q < 2'(BUF_DEPTH)) | pop;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (evt) begin
                    if (space) begin
                        capture = 1'b1;
                    end else begin
                        state_d = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if (evt) begin
                    err_d = 1'b1;
                end
                if (space) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        if (capture) begin
            ack_d = ~ack_q;
            cnt_d = cnt_q + CNT_W'(1);
        end
        unique case ({pop, capture})
            2'b10: begin
                count_d = count_q - 2'd1;
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
            end
            2'b01: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) begin
                    head_d = req_data;
                end else begin
                    tail_d = req_data;
                end
            end
            2'b11: begin
                // Occupancy unchanged: the incoming word goes behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = req_data;
                end else begin
                    head_d = tail_q;
                    tail_d = req_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            req_d_q <= 1'b0;
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            req_d_q <= req_s;
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack_tgl    = ack_q;
    assign dout_valid = (count_q != 2'd0);
    assign dout_data  = head_q;
    assign evt_cnt    = cnt_q;
    assign busy       = (state_q == WAIT_SPACE);
    assign err_proto  = err_q;

endmodule
